// File: rtl/fsm.sv
// Traffic-light controller for a main road / side road crossing.
// Lamps and the start-timer pulse are registered and follow the state register.
module fsm (
    input  logic Clk,
    input  logic reset,
    input  logic C,
    input  logic TS,
    input  logic TL,
    output logic MR,
    output logic MY,
    output logic MG,
    output logic SR,
    output logic SY,
    output logic SG,
    output logic ST
);

    typedef enum logic [1:0] {
        MAIN_GREEN  = 2'b00,
        MAIN_YELLOW = 2'b01,
        SIDE_GREEN  = 2'b10,
        SIDE_YELLOW = 2'b11
    } state_t;

    // Lamp vector order: {MR, MY, MG, SR, SY, SG}
    localparam logic [5:0] LAMPS_MAIN_GREEN  = 6'b001_100;
    localparam logic [5:0] LAMPS_MAIN_YELLOW = 6'b010_100;
    localparam logic [5:0] LAMPS_SIDE_GREEN  = 6'b100_001;
    localparam logic [5:0] LAMPS_SIDE_YELLOW = 6'b100_010;

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_lamps;
    logic       r_st;

    function automatic logic [5:0] lamps_f(input state_t s);
        logic [5:0] l;
        case (s)
            MAIN_GREEN:  l = LAMPS_MAIN_GREEN;
            MAIN_YELLOW: l = LAMPS_MAIN_YELLOW;
            SIDE_GREEN:  l = LAMPS_SIDE_GREEN;
            SIDE_YELLOW: l = LAMPS_SIDE_YELLOW;
            default:     l = LAMPS_MAIN_GREEN;
        endcase
        return l;
    endfunction

    // Next-state logic: only the inputs relevant to the current state are examined.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MAIN_GREEN: begin
                if (C && TL) w_next_state = MAIN_YELLOW;
                else         w_next_state = MAIN_GREEN;
            end
            MAIN_YELLOW: begin
                if (TS) w_next_state = SIDE_GREEN;
                else    w_next_state = MAIN_YELLOW;
            end
            SIDE_GREEN: begin
                if (!C || TL) w_next_state = SIDE_YELLOW;
                else          w_next_state = SIDE_GREEN;
            end
            SIDE_YELLOW: begin
                if (TS) w_next_state = MAIN_GREEN;
                else    w_next_state = SIDE_YELLOW;
            end
            default: w_next_state = MAIN_GREEN;
        endcase
    end

    // State, lamp and timer-pulse registers; lamps are decoded from the next state
    // so they change on the same edge as the state itself.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= MAIN_GREEN;
            r_lamps <= LAMPS_MAIN_GREEN;
            r_st    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_lamps <= lamps_f(w_next_state);
            r_st    <= (w_next_state != r_state);
        end
    end

    assign {MR, MY, MG, SR, SY, SG} = r_lamps;
    assign ST = r_st;

endmodule

// File: tb/tb_fsm.sv
// Directed, table-driven bench for the traffic-light controller,
// plus hand sequences for asynchronous reset and the timer-pulse count.
`timescale 1ns/1ps
module tb_fsm;

    logic Clk;
    logic reset;
    logic C, TS, TL;
    logic MR, MY, MG, SR, SY, SG, ST;

    fsm dut (
        .Clk  (Clk),
        .reset(reset),
        .C    (C),
        .TS   (TS),
        .TL   (TL),
        .MR   (MR),
        .MY   (MY),
        .MG   (MG),
        .SR   (SR),
        .SY   (SY),
        .SG   (SG),
        .ST   (ST)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // {MR, MY, MG, SR, SY, SG}
    localparam logic [5:0] L_MG = 6'b001_100;
    localparam logic [5:0] L_MY = 6'b010_100;
    localparam logic [5:0] L_SG = 6'b100_001;
    localparam logic [5:0] L_SY = 6'b100_010;

    typedef struct {
        logic       rst;
        logic       c;
        logic       ts;
        logic       tl;
        logic [5:0] exp_lamps;
        logic       exp_st;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   st_cnt;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got lamps/st=%b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {MR, MY, MG, SR, SY, SG, ST};
    endfunction

    task automatic step(input logic r, input logic c, input logic ts, input logic tl);
        reset = r; C = c; TS = ts; TL = tl;
        @(posedge Clk);
        #1;
    endtask

    task automatic add(input logic r, input logic c, input logic ts, input logic tl,
                       input logic [5:0] l, input logic st);
        vec_t v;
        v.rst = r; v.c = c; v.ts = ts; v.tl = tl; v.exp_lamps = l; v.exp_st = st;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; C = 1'b0; TS = 1'b0; TL = 1'b0;
        #2 reset = 1'b0;
        #1 check("reset_async_initial", outs(), {L_MG, 1'b0});

        // Reset held with every input active
        add(0, 1, 1, 1, L_MG, 0);
        add(0, 1, 1, 1, L_MG, 0);
        add(0, 1, 1, 1, L_MG, 0);
        // Main green: partial conditions never advance
        add(1, 0, 0, 0, L_MG, 0);
        add(1, 1, 0, 0, L_MG, 0);
        add(1, 1, 0, 0, L_MG, 0);
        add(1, 0, 0, 1, L_MG, 0);
        add(1, 0, 0, 1, L_MG, 0);
        add(1, 0, 1, 0, L_MG, 0);
        // Full cycle with holds and ignored inputs
        add(1, 1, 0, 1, L_MY, 1);
        add(1, 1, 0, 1, L_MY, 0);
        add(1, 0, 0, 0, L_MY, 0);
        add(1, 0, 1, 0, L_SG, 1);
        add(1, 1, 1, 0, L_SG, 0);
        add(1, 1, 0, 0, L_SG, 0);
        add(1, 1, 0, 1, L_SY, 1);
        add(1, 0, 0, 1, L_SY, 0);
        add(1, 0, 1, 0, L_MG, 1);
        add(1, 0, 0, 0, L_MG, 0);
        // Back-to-back transitions keep ST high each following cycle
        add(1, 1, 1, 1, L_MY, 1);
        add(1, 1, 1, 1, L_SG, 1);
        add(1, 0, 0, 0, L_SY, 1);
        add(1, 0, 1, 0, L_MG, 1);
        add(1, 0, 0, 0, L_MG, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].c, vecs[i].ts, vecs[i].tl);
            check($sformatf("vec%0d", i), outs(), {vecs[i].exp_lamps, vecs[i].exp_st});
        end

        // Full cycle counting ST pulses
        st_cnt = 0;
        step(1, 1, 0, 1); st_cnt += int'(ST);
        step(1, 1, 0, 0); st_cnt += int'(ST);
        step(1, 1, 1, 0); st_cnt += int'(ST);
        step(1, 1, 0, 0); st_cnt += int'(ST);
        step(1, 0, 0, 0); st_cnt += int'(ST);
        step(1, 0, 0, 0); st_cnt += int'(ST);
        step(1, 0, 1, 0); st_cnt += int'(ST);
        step(1, 0, 0, 0); st_cnt += int'(ST);
        check("full_cycle_end_state", outs(), {L_MG, 1'b0});
        check("full_cycle_st_pulses", 7'(st_cnt), 7'd4);

        // Asynchronous reset between edges while in SIDE_GREEN
        step(1, 1, 0, 1);
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        check("side_green_before_reset", outs(), {L_SG, 1'b0});
        #2 reset = 1'b0;
        #1 check("reset_mid_side_green", outs(), {L_MG, 1'b0});
        #1 reset = 1'b1;

        // Reset clears a pending ST immediately, then first edge runs normally
        step(1, 1, 0, 1);
        check("main_yellow_st", outs(), {L_MY, 1'b1});
        #1 reset = 1'b0;
        #1 check("reset_clears_st", outs(), {L_MG, 1'b0});
        #1 reset = 1'b1;
        step(1, 1, 0, 1);
        check("first_edge_after_reset", outs(), {L_MY, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fsm.md
FSM -- requirements
Module: fsm

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 C  input  1  side-road car sensor; 1 = vehicle waiting on the side road.
REQ-005 TS  input  1  short-timer-expired flag from the external interval timer (yellow duration).
REQ-006 TL  input  1  long-timer-expired flag from the external interval timer (minimum green duration).
REQ-007 MR, MY, MG  output  1 each  main-road red, yellow and green lamps.
REQ-008 SR, SY, SG  output  1 each  side-road red, yellow and green lamps.
REQ-009 ST  output  1  start-timer pulse; restarts the external interval timer.

Function
REQ-010 fsm SHALL be a four-state machine with states MAIN_GREEN, MAIN_YELLOW, SIDE_GREEN and SIDE_YELLOW, held in a 2-bit state register; all four encodings are legal.
REQ-011 Lamp outputs SHALL be Moore outputs decoded only from the current state, with no combinational path from C, TS or TL to any lamp output.
REQ-012 MAIN_GREEN: MG=1, SR=1; all other lamps 0.
REQ-013 MAIN_YELLOW: MY=1, SR=1; all other lamps 0.
REQ-014 SIDE_GREEN: MR=1, SG=1; all other lamps 0.
REQ-015 SIDE_YELLOW: MR=1, SY=1; all other lamps 0.
REQ-016 In every state exactly one main lamp and exactly one side lamp SHALL be 1, and MG and SG SHALL never be 1 together.
REQ-017 MAIN_GREEN -> MAIN_YELLOW when C=1 AND TL=1 at the rising edge; otherwise remain in MAIN_GREEN.
REQ-018 MAIN_YELLOW -> SIDE_GREEN when TS=1 at the rising edge; otherwise remain; C and TL are ignored in this state.
REQ-019 SIDE_GREEN -> SIDE_YELLOW when C=0 OR TL=1 at the rising edge; otherwise remain; TS is ignored.
REQ-020 SIDE_YELLOW -> MAIN_GREEN when TS=1 at the rising edge; otherwise remain; C and TL are ignored.
REQ-021 When several inputs are active in the same cycle, only the inputs named for the current state SHALL be evaluated, and at most one transition SHALL occur per clock edge.
REQ-022 ST SHALL be a registered output that is 1 for exactly one clock cycle, the cycle immediately following every state transition, and 0 in every other cycle.
REQ-023 Transition latency SHALL be one clock: the new lamp pattern and ST=1 both appear after the same rising edge that samples the qualifying condition.
REQ-024 A cycle with no transition SHALL leave the state and all outputs unchanged, apart from ST returning to 0.

Reset
REQ-025 While reset=0 the state SHALL be forced to MAIN_GREEN immediately, without waiting for Clk.
REQ-026 While reset=0 the outputs SHALL be MG=1, SR=1, MR=0, MY=0, SY=0, SG=0, ST=0.
REQ-027 Reset asserted in any state, mid-sequence, SHALL abort the sequence and take effect asynchronously.
REQ-028 After reset is released, the first rising edge SHALL evaluate the MAIN_GREEN transition rule normally.

Verification
REQ-029 Hold reset=0 across several edges with C=1, TL=1, TS=1 -> MG=1, SR=1, ST=0 throughout, and no state change occurs.
REQ-030 From MAIN_GREEN, set C=1 and TL=1 for one edge -> MY=1, SR=1, ST=1 for one cycle, then ST=0 with state held while TS=0.
REQ-031 From MAIN_GREEN, set C=1, TL=0 and then C=0, TL=1 over many edges -> the machine stays in MAIN_GREEN and ST stays 0.
REQ-032 Run a full cycle: C=1/TL=1, then TS=1, then C=0, then TS=1 -> the state visits MAIN_YELLOW, SIDE_GREEN, SIDE_YELLOW and back to MAIN_GREEN, with one ST pulse per transition (four pulses in total).
REQ-033 In SIDE_GREEN with C=1, TL=0 -> the state holds; raising TL=1 -> SIDE_YELLOW on the next edge, with MR=1, SY=1.
REQ-034 Drive reset=0 between clock edges while in SIDE_GREEN -> MG=1, SR=1, SG=0, ST=0 immediately, before the next edge.
